// File: rtl/iq_burst_detector_if.sv
// rtl/iq_burst_detector_if.sv - sample, threshold and detection signal bundle for iq_burst_detector
interface iq_burst_detector_if #(
  parameter int BIT_WIDTH = 16,
  parameter int IDX_WIDTH = 16
);
  logic                        strobe_in;
  logic                        clear;
  logic signed [BIT_WIDTH-1:0] i_in;
  logic signed [BIT_WIDTH-1:0] q_in;
  logic [BIT_WIDTH:0]          thresh_hi;
  logic [BIT_WIDTH:0]          thresh_lo;
  logic [BIT_WIDTH:0]          mag_out;
  logic                        mag_valid;
  logic [BIT_WIDTH:0]          avg_out;
  logic                        avg_valid;
  logic                        detect;
  logic                        done;
  logic [BIT_WIDTH:0]          peak_mag;
  logic [IDX_WIDTH-1:0]        peak_index;

  modport master (
    output strobe_in, clear, i_in, q_in, thresh_hi, thresh_lo,
    input  mag_out, mag_valid, avg_out, avg_valid, detect, done, peak_mag, peak_index
  );

  modport slave (
    input  strobe_in, clear, i_in, q_in, thresh_hi, thresh_lo,
    output mag_out, mag_valid, avg_out, avg_valid, detect, done, peak_mag, peak_index
  );
endinterface

// File: rtl/iq_burst_detector.sv
// rtl/iq_burst_detector.sv - IQ magnitude, window average and hysteretic burst detect FSM
// Peak magnitude/index tracking is built only when IQ_BURST_PEAK_EN is defined.
module iq_burst_detector #(
  parameter int BIT_WIDTH = 16,
  parameter int WIN_LOG2  = 4,
  parameter int HOLDOFF   = 8,
  parameter int IDX_WIDTH = 16
) (
  input logic             clock,
  input logic             reset,
  iq_burst_detector_if.slave bus
);
  localparam int MW  = BIT_WIDTH + 1;
  localparam int AW  = MW + WIN_LOG2;
  localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLDOFF} state_t;

  logic [BIT_WIDTH-1:0] a_q, a_d, b_q, b_d, mx, mn;
  logic                 s1_valid_q, s1_valid_d;
  logic [MW-1:0]        mag_q, mag_d, avg_q, avg_d;
  logic                 mag_valid_q, mag_valid_d, avg_valid_q, avg_valid_d;
  logic [AW-1:0]        acc_q, acc_d, acc_sum;
  logic [WIN_LOG2-1:0]  wcount_q, wcount_d;
  state_t               state_q, state_d;
  logic [HCW-1:0]       hcount_q, hcount_d;
  logic                 done_q, done_d;
`ifdef IQ_BURST_PEAK_EN
  logic [IDX_WIDTH-1:0] idx_q, idx_d, peak_index_q, peak_index_d;
  logic [MW-1:0]        peak_mag_q, peak_mag_d;
`endif

  // The most negative code has no positive twin, so it saturates one below.
  function automatic logic [BIT_WIDTH-1:0] abs_sat(input logic signed [BIT_WIDTH-1:0] x);
    logic [BIT_WIDTH-1:0] ux;
    ux = x;
    if (ux == {1'b1, {(BIT_WIDTH-1){1'b0}}}) return {1'b0, {(BIT_WIDTH-1){1'b1}}};
    else if (ux[BIT_WIDTH-1])                return ~ux + 1'b1;
    else                                     return ux;
  endfunction

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    s1_valid_d  = bus.strobe_in;
    mag_d       = mag_q;
    mag_valid_d = s1_valid_q;
    acc_d       = acc_q;
    wcount_d    = wcount_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    state_d     = state_q;
    hcount_d    = hcount_q;
    done_d      = 1'b0;
    mx          = (a_q >= b_q) ? a_q : b_q;
    mn          = (a_q >= b_q) ? b_q : a_q;
    acc_sum     = acc_q + AW'(mag_q);
`ifdef IQ_BURST_PEAK_EN
    idx_d        = idx_q;
    peak_mag_d   = peak_mag_q;
    peak_index_d = peak_index_q;
`endif

    if (bus.strobe_in) begin
      a_d = abs_sat(bus.i_in);
      b_d = abs_sat(bus.q_in);
    end
    if (s1_valid_q)
      mag_d = {1'b0, mx} + MW'(mn >> 2) + MW'(mn >> 3);

    if (mag_valid_q) begin
      wcount_d = wcount_q + 1'b1;
      if (wcount_q == {WIN_LOG2{1'b1}}) begin
        avg_d       = MW'(acc_sum >> WIN_LOG2);
        avg_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = acc_sum;
      end
    end

`ifdef IQ_BURST_PEAK_EN
    if (state_q == S_ACTIVE && mag_valid_q) begin
      if (mag_q > peak_mag_q) begin
        peak_mag_d   = mag_q;
        peak_index_d = idx_q;
      end
      if (idx_q != {IDX_WIDTH{1'b1}}) idx_d = idx_q + 1'b1;
    end
`endif

    if (avg_valid_q) begin
      case (state_q)
        S_IDLE: if (avg_q >= bus.thresh_hi) begin
          state_d = S_ACTIVE;
`ifdef IQ_BURST_PEAK_EN
          idx_d        = '0;
          peak_mag_d   = '0;
          peak_index_d = '0;
`endif
        end
        S_ACTIVE: if (avg_q < bus.thresh_lo) begin
          state_d  = S_HOLDOFF;
          done_d   = 1'b1;
          hcount_d = '0;
        end
        S_HOLDOFF: begin
          if (hcount_q == HCW'(HOLDOFF - 1)) state_d = S_IDLE;
          else                               hcount_d = hcount_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Flush wins over everything but leaves the last burst's peak visible.
    if (bus.clear) begin
      s1_valid_d  = 1'b0;
      mag_valid_d = 1'b0;
      avg_valid_d = 1'b0;
      acc_d       = '0;
      wcount_d    = '0;
      state_d     = S_IDLE;
      hcount_d    = '0;
      done_d      = 1'b0;
`ifdef IQ_BURST_PEAK_EN
      idx_d = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q         <= '0;
      b_q         <= '0;
      s1_valid_q  <= 1'b0;
      mag_q       <= '0;
      mag_valid_q <= 1'b0;
      acc_q       <= '0;
      wcount_q    <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      state_q     <= S_IDLE;
      hcount_q    <= '0;
      done_q      <= 1'b0;
`ifdef IQ_BURST_PEAK_EN
      idx_q        <= '0;
      peak_mag_q   <= '0;
      peak_index_q <= '0;
`endif
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      s1_valid_q  <= s1_valid_d;
      mag_q       <= mag_d;
      mag_valid_q <= mag_valid_d;
      acc_q       <= acc_d;
      wcount_q    <= wcount_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      state_q     <= state_d;
      hcount_q    <= hcount_d;
      done_q      <= done_d;
`ifdef IQ_BURST_PEAK_EN
      idx_q        <= idx_d;
      peak_mag_q   <= peak_mag_d;
      peak_index_q <= peak_index_d;
`endif
    end
  end

  assign bus.mag_out   = mag_q;
  assign bus.mag_valid = mag_valid_q;
  assign bus.avg_out   = avg_q;
  assign bus.avg_valid = avg_valid_q;
  assign bus.detect    = (state_q == S_ACTIVE);
  assign bus.done      = done_q;
`ifdef IQ_BURST_PEAK_EN
  assign bus.peak_mag   = peak_mag_q;
  assign bus.peak_index = peak_index_q;
`else
  assign bus.peak_mag   = '0;
  assign bus.peak_index = {IDX_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_iq_burst_detector.sv
// tb/tb_iq_burst_detector.sv - directed self-checking bench for iq_burst_detector
module tb_iq_burst_detector;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int avg_cnt = 0;
  int done_cnt = 0;
  int base_avg, base_done;
  logic [16:0] last_avg = '0;
  logic [15:0] peak_m_exp;
  logic [15:0] peak_i_exp;

  iq_burst_detector_if #(.BIT_WIDTH(16), .IDX_WIDTH(16)) bus ();

  iq_burst_detector #(
    .BIT_WIDTH(16), .WIN_LOG2(4), .HOLDOFF(8), .IDX_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.avg_valid) begin
      avg_cnt  = avg_cnt + 1;
      last_avg = bus.avg_out;
    end
    if (bus.done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic stream(input int i, input int q, input int n);
    bus.i_in      = 16'(i);
    bus.q_in      = 16'(q);
    bus.strobe_in = 1'b1;
    repeat (n) tick();
    bus.strobe_in = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic mag_vec(input string tag, input int i, input int q, input int exp);
    stream(i, q, 1);
    tick();
    check({tag, "_valid"}, bus.mag_valid, 1);
    check(tag, bus.mag_out, exp);
  endtask

  initial begin
    bus.strobe_in = 1'b0;
    bus.clear     = 1'b0;
    bus.i_in      = '0;
    bus.q_in      = '0;
    bus.thresh_hi = 17'h1FFFF;
    bus.thresh_lo = 17'd0;
`ifdef IQ_BURST_PEAK_EN
    peak_m_exp = 16'd5000;
    peak_i_exp = 16'd1;
`else
    peak_m_exp = 16'd0;
    peak_i_exp = 16'd0;
`endif

    repeat (3) tick();
    check("rst_mag_out", bus.mag_out, 0);
    check("rst_mag_valid", bus.mag_valid, 0);
    check("rst_avg_out", bus.avg_out, 0);
    check("rst_avg_valid", bus.avg_valid, 0);
    check("rst_detect", bus.detect, 0);
    check("rst_done", bus.done, 0);
    check("rst_peak_mag", bus.peak_mag, 0);
    check("rst_peak_index", bus.peak_index, 0);
    reset = 1'b1;
    tick();

    // Latency: strobe in cycle k gives mag_valid in cycle k+2 only.
    stream(1000, 0, 1);
    check("lat1_valid", bus.mag_valid, 0);
    tick();
    check("lat2_valid", bus.mag_valid, 1);
    check("lat2_mag", bus.mag_out, 1000);
    tick();
    check("lat3_gap", bus.mag_valid, 0);
    do_clear();

    mag_vec("mag_1000_0", 1000, 0, 1000);
    mag_vec("mag_min_min", -32768, -32768, 45053);
    mag_vec("mag_3000_m1000", 3000, -1000, 3375);
    mag_vec("mag_m1000_3000", -1000, 3000, 3375);
    mag_vec("mag_0_m32767", 0, -32767, 32767);
    mag_vec("mag_m4_8", -4, 8, 9);
    mag_vec("mag_100_100", 100, 100, 137);
    do_clear();

    base_avg = avg_cnt;
    stream(1000, 0, 32);
    drain();
    check("win_cont_count", avg_cnt - base_avg, 2);
    check("win_cont_avg", last_avg, 1000);

    do_clear();
    stream(1000, 0, 15);
    stream(1015, 0, 1);
    drain();
    check("win_trunc_avg", last_avg, 1000);
    stream(3000, -1000, 16);
    drain();
    check("win_3375_avg", last_avg, 3375);

    do_clear();
    base_avg = avg_cnt;
    for (int k = 0; k < 15; k++) begin
      stream(1000, 0, 1);
      tick();
    end
    drain();
    check("gap_15_count", avg_cnt - base_avg, 0);
    stream(1000, 0, 1);
    drain();
    check("gap_16_count", avg_cnt - base_avg, 1);
    check("gap_avg", last_avg, 1000);

    do_clear();
    bus.thresh_hi = 17'd2000;
    bus.thresh_lo = 17'd1000;
    base_done = done_cnt;
    stream(3000, 0, 16);
    drain();
    check("fsm_detect_3000", bus.detect, 1);
    stream(1500, 0, 16);
    drain();
    check("fsm_hyst_1500", bus.detect, 1);
    check("fsm_no_done_yet", done_cnt - base_done, 0);
    stream(500, 0, 16);
    drain();
    check("fsm_end_500", bus.detect, 0);
    check("fsm_done_pulse", done_cnt - base_done, 1);
    for (int w = 0; w < 8; w++) begin
      stream(3000, 0, 16);
      drain();
      check($sformatf("fsm_holdoff_w%0d", w), bus.detect, 0);
    end
    stream(3000, 0, 16);
    drain();
    check("fsm_redetect", bus.detect, 1);

    bus.strobe_in = 1'b1;
    bus.q_in = 16'd0;
    bus.i_in = 16'd3000; tick();
    bus.i_in = 16'd5000; tick();
    tick();
    bus.i_in = 16'd4000; tick();
    bus.strobe_in = 1'b0;
    drain();
    check("peak_mag", bus.peak_mag, 32'(peak_m_exp));
    check("peak_index", bus.peak_index, 32'(peak_i_exp));

    base_avg  = avg_cnt;
    base_done = done_cnt;
    stream(3000, 0, 8);
    do_clear();
    check("clr_detect", bus.detect, 0);
    stream(3000, 0, 12);
    drain();
    check("clr_no_avg", avg_cnt - base_avg, 0);
    check("clr_no_done", done_cnt - base_done, 0);
    check("clr_idle", bus.detect, 0);
    check("clr_peak_mag", bus.peak_mag, 32'(peak_m_exp));
    check("clr_peak_index", bus.peak_index, 32'(peak_i_exp));

    stream(3000, 0, 4);
    drain();
    check("rst2_active", bus.detect, 1);
    bus.i_in      = 16'd5000;
    bus.strobe_in = 1'b1;
    tick();
    tick();
    check("rst2_pre_valid", bus.mag_valid, 1);
    #1 reset = 1'b0;
    #1;
    check("rst2_detect", bus.detect, 0);
    check("rst2_mag_valid", bus.mag_valid, 0);
    check("rst2_mag_out", bus.mag_out, 0);
    check("rst2_avg_out", bus.avg_out, 0);
    check("rst2_done", bus.done, 0);
    check("rst2_peak_mag", bus.peak_mag, 0);
    check("rst2_peak_index", bus.peak_index, 0);
    bus.strobe_in = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
